// File: rtl/unified_cache_mem_request_merger_if.sv
// Bank-side miss/writeback request ports and the merged memory-side request port.
// The bank and memory side act as master; the merger is the slave.
interface unified_cache_mem_request_merger_if #(
  parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = 32
);
  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] miss_request_in;
  logic                                          miss_request_valid_in;
  logic                                          miss_request_critical_in;
  logic                                          miss_request_ack_out;
  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] writeback_request_in;
  logic                                          writeback_request_valid_in;
  logic                                          writeback_request_critical_in;
  logic                                          writeback_request_ack_out;
  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] mem_request_out;
  logic                                          mem_request_valid_out;
  logic                                          mem_request_critical_out;
  logic                                          mem_request_ack_in;

  modport slave (
    input  miss_request_in, miss_request_valid_in, miss_request_critical_in,
    output miss_request_ack_out,
    input  writeback_request_in, writeback_request_valid_in, writeback_request_critical_in,
    output writeback_request_ack_out,
    output mem_request_out, mem_request_valid_out, mem_request_critical_out,
    input  mem_request_ack_in
  );

  modport master (
    output miss_request_in, miss_request_valid_in, miss_request_critical_in,
    input  miss_request_ack_out,
    output writeback_request_in, writeback_request_valid_in, writeback_request_critical_in,
    input  writeback_request_ack_out,
    input  mem_request_out, mem_request_valid_out, mem_request_critical_out,
    output mem_request_ack_in
  );
endinterface

// File: rtl/unified_cache_mem_request_merger.sv
// Merges bank miss/writeback requests onto one registered memory request port; push->valid_out in 2 cycles.
// Backpressure: a full source FIFO withholds its ack; the output holds until mem_request_ack_in.
module unified_cache_mem_request_merger_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign head_vld = (count_q != '0);
  assign head_dat = mem_q[rd_ptr_q];

  // Caller only pushes when not full and only pops when a head exists.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_rdy) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_vld, pop_rdy})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module unified_cache_mem_request_merger #(
  parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = 32,
  parameter int QUEUE_DEPTH  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk_in,
  input  logic reset_in,
  unified_cache_mem_request_merger_if.slave io
);
  localparam int PKT_W = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic             miss_ack_q, miss_ack_d, wb_ack_q, wb_ack_d;
  logic [CW-1:0]    starve_q, starve_d;
  logic [PKT_W-1:0] out_pkt_q, out_pkt_d;
  logic             out_crit_q, out_crit_d;
  logic             miss_push, wb_push, miss_pop, wb_pop, miss_full, wb_full;
  logic             miss_head_vld, wb_head_vld, miss_crit, wb_crit, pick_miss;
  logic [PKT_W:0]   miss_head, wb_head;

  // A cycle that shows the ack belongs to the already-captured packet, so never capture in it.
  assign miss_push  = io.miss_request_valid_in && !miss_full && !miss_ack_q;
  assign wb_push    = io.writeback_request_valid_in && !wb_full && !wb_ack_q;
  assign miss_ack_d = miss_push;
  assign wb_ack_d   = wb_push;

  unified_cache_mem_request_merger_fifo #(.WIDTH(PKT_W + 1), .DEPTH(QUEUE_DEPTH)) u_miss_fifo (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .push_vld (miss_push),
    .push_dat ({io.miss_request_critical_in, io.miss_request_in}),
    .pop_rdy  (miss_pop),
    .head_vld (miss_head_vld),
    .head_dat (miss_head),
    .full     (miss_full)
  );

  unified_cache_mem_request_merger_fifo #(.WIDTH(PKT_W + 1), .DEPTH(QUEUE_DEPTH)) u_wb_fifo (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .push_vld (wb_push),
    .push_dat ({io.writeback_request_critical_in, io.writeback_request_in}),
    .pop_rdy  (wb_pop),
    .head_vld (wb_head_vld),
    .head_dat (wb_head),
    .full     (wb_full)
  );

  assign miss_crit = miss_head_vld && miss_head[PKT_W];
  assign wb_crit   = wb_head_vld && wb_head[PKT_W];

  always_comb begin
    state_d    = state_q;
    out_pkt_d  = out_pkt_q;
    out_crit_d = out_crit_q;
    starve_d   = starve_q;
    miss_pop   = 1'b0;
    wb_pop     = 1'b0;
    pick_miss  = 1'b0;

    // Starvation override, then a lone critical head, then writeback preference.
    if (starve_q == LIMIT && miss_head_vld) pick_miss = 1'b1;
    else if (miss_crit != wb_crit)          pick_miss = miss_crit;
    else                                    pick_miss = !wb_head_vld;

    case (state_q)
      IDLE: begin
        if (miss_head_vld || wb_head_vld) begin
          state_d = BUSY;
          if (pick_miss) begin
            miss_pop                = 1'b1;
            {out_crit_d, out_pkt_d} = miss_head;
            starve_d                = '0;
          end else begin
            wb_pop                  = 1'b1;
            {out_crit_d, out_pkt_d} = wb_head;
            if (miss_head_vld && starve_q != LIMIT) starve_d = starve_q + 1'b1;
          end
        end
      end
      BUSY: begin
        if (io.mem_request_ack_in) state_d = IDLE;
      end
    endcase

    if (!miss_head_vld) starve_d = '0;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      miss_ack_q <= 1'b0;
      wb_ack_q   <= 1'b0;
      starve_q   <= '0;
      out_pkt_q  <= '0;
      out_crit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      miss_ack_q <= miss_ack_d;
      wb_ack_q   <= wb_ack_d;
      starve_q   <= starve_d;
      out_pkt_q  <= out_pkt_d;
      out_crit_q <= out_crit_d;
    end
  end

  assign io.miss_request_ack_out      = miss_ack_q;
  assign io.writeback_request_ack_out = wb_ack_q;
  assign io.mem_request_out           = out_pkt_q;
  assign io.mem_request_valid_out     = (state_q == BUSY);
  assign io.mem_request_critical_out  = out_crit_q;
endmodule

// File: tb/tb_unified_cache_mem_request_merger.sv
// Directed bench for the request merger: queue-based reference model checked every cycle,
// plus hand-computed issue orders and timings.
module tb_unified_cache_mem_request_merger;
  localparam int PKT_W = 8;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  typedef struct {
    logic [PKT_W-1:0] pkt;
    logic             crit;
  } ent_t;

  logic clk_in = 1'b0;
  logic reset_in = 1'b1;
  always #5 clk_in = ~clk_in;

  unified_cache_mem_request_merger_if #(.UNIFIED_CACHE_PACKET_WIDTH_IN_BITS(PKT_W)) io ();

  unified_cache_mem_request_merger #(
    .UNIFIED_CACHE_PACKET_WIDTH_IN_BITS(PKT_W),
    .QUEUE_DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .io       (io)
  );

  int errors = 0;
  int checks = 0;
  int miss_acks = 0;
  logic [PKT_W-1:0] issued[$];
  logic [PKT_W-1:0] exp_q[$];
  ent_t m_pend[$], w_pend[$];
  ent_t m_drop, w_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic push_m(input logic [PKT_W-1:0] p, input logic c);
    ent_t e;
    e.pkt = p;
    e.crit = c;
    m_pend.push_back(e);
  endtask

  task automatic push_w(input logic [PKT_W-1:0] p, input logic c);
    ent_t e;
    e.pkt = p;
    e.crit = c;
    w_pend.push_back(e);
  endtask

  task automatic wait_issued(input int n, input int budget);
    for (int i = 0; i < budget && issued.size() < n; i++) @(posedge clk_in);
    #2;
  endtask

  task automatic cmp_issued(input string name);
    check({name, "_count"}, issued.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < issued.size()) check(name, issued[i], exp_q[i]);
    end
  endtask

  // Requesters: hold each packet until its ack pulse is seen, then present the next.
  initial begin
    io.miss_request_valid_in = 1'b0;
    io.miss_request_in = '0;
    io.miss_request_critical_in = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (io.miss_request_ack_out === 1'b1 && m_pend.size() > 0) m_drop = m_pend.pop_front();
      if (m_pend.size() > 0) begin
        io.miss_request_valid_in = 1'b1;
        io.miss_request_in = m_pend[0].pkt;
        io.miss_request_critical_in = m_pend[0].crit;
      end else begin
        io.miss_request_valid_in = 1'b0;
      end
    end
  end

  initial begin
    io.writeback_request_valid_in = 1'b0;
    io.writeback_request_in = '0;
    io.writeback_request_critical_in = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (io.writeback_request_ack_out === 1'b1 && w_pend.size() > 0) w_drop = w_pend.pop_front();
      if (w_pend.size() > 0) begin
        io.writeback_request_valid_in = 1'b1;
        io.writeback_request_in = w_pend[0].pkt;
        io.writeback_request_critical_in = w_pend[0].crit;
      end else begin
        io.writeback_request_valid_in = 1'b0;
      end
    end
  end

  // Reference model: two packet queues, one output slot, a starvation count.
  ent_t mq[$], wq[$];
  ent_t sel;
  bit   armed = 0;
  bit   m_ack = 0, w_ack = 0, o_vld = 0, o_crit = 0;
  logic [PKT_W-1:0] o_pkt = '0;
  int   starve = 0;

  always @(negedge clk_in) begin : model
    bit mc, wc, m_was_empty, take_miss, mh, wh, mcr, wcr;
    if (armed) begin
      check("miss_ack", io.miss_request_ack_out, m_ack);
      check("wb_ack", io.writeback_request_ack_out, w_ack);
      check("mem_valid", io.mem_request_valid_out, o_vld);
      if (o_vld) begin
        check("mem_pkt", io.mem_request_out, o_pkt);
        check("mem_crit", io.mem_request_critical_out, o_crit);
      end
    end
    if (io.mem_request_valid_out === 1'b1 && io.mem_request_ack_in === 1'b1)
      issued.push_back(io.mem_request_out);
    if (io.miss_request_ack_out === 1'b1) miss_acks++;

    if (reset_in) begin
      mq.delete();
      wq.delete();
      o_vld = 0; o_pkt = '0; o_crit = 0;
      m_ack = 0; w_ack = 0; starve = 0;
      armed = 1;
    end else begin
      mc = io.miss_request_valid_in && mq.size() < DEPTH && !m_ack;
      wc = io.writeback_request_valid_in && wq.size() < DEPTH && !w_ack;
      m_was_empty = (mq.size() == 0);
      mh = (mq.size() > 0);
      wh = (wq.size() > 0);
      if (o_vld) begin
        if (io.mem_request_ack_in) o_vld = 0;
      end else if (mh || wh) begin
        mcr = mh && mq[0].crit;
        wcr = wh && wq[0].crit;
        if (starve == LIMIT && mh) take_miss = 1;
        else if (mcr && !wcr)      take_miss = 1;
        else if (wcr && !mcr)      take_miss = 0;
        else                       take_miss = !wh;
        if (take_miss) begin
          sel = mq.pop_front();
          starve = 0;
        end else begin
          sel = wq.pop_front();
          if (mh && starve < LIMIT) starve++;
        end
        o_vld = 1;
        o_pkt = sel.pkt;
        o_crit = sel.crit;
      end
      if (m_was_empty) starve = 0;
      if (mc) begin
        sel.pkt = io.miss_request_in; sel.crit = io.miss_request_critical_in;
        mq.push_back(sel);
      end
      if (wc) begin
        sel.pkt = io.writeback_request_in; sel.crit = io.writeback_request_critical_in;
        wq.push_back(sel);
      end
      m_ack = mc;
      w_ack = wc;
    end
  end

  initial begin
    io.mem_request_ack_in = 1'b0;
    reset_in = 1'b1;
    repeat (3) step();
    check("rst_valid", io.mem_request_valid_out, 0);
    check("rst_miss_ack", io.miss_request_ack_out, 0);
    check("rst_wb_ack", io.writeback_request_ack_out, 0);
    check("rst_pkt", io.mem_request_out, 0);
    reset_in = 1'b0;
    step();

    // Single miss: ack at T+1, valid at T+2, ack_in at T+4, drop at T+5.
    issued.delete();
    push_m(8'hA1, 1'b0);
    step();
    step(); check("t1_ack_T1", io.miss_request_ack_out, 1);
    step(); check("t1_valid_T2", io.mem_request_valid_out, 1);
            check("t1_pkt_T2", io.mem_request_out, 8'hA1);
    step(); check("t1_hold_T3", io.mem_request_valid_out, 1);
    step(); check("t1_hold_T4", io.mem_request_valid_out, 1);
    io.mem_request_ack_in = 1'b1;
    step(); check("t1_drop_T5", io.mem_request_valid_out, 0);
    io.mem_request_ack_in = 1'b0;
    repeat (3) step();

    // Simultaneous, non-critical: writeback first.
    io.mem_request_ack_in = 1'b1;
    issued.delete();
    push_m(8'h11, 1'b0);
    push_w(8'h22, 1'b0);
    wait_issued(2, 40);
    exp_q.delete(); exp_q.push_back(8'h22); exp_q.push_back(8'h11);
    cmp_issued("t2_order");
    repeat (4) step();

    // Critical miss beats non-critical writeback.
    issued.delete();
    push_m(8'h11, 1'b1);
    push_w(8'h22, 1'b0);
    wait_issued(2, 40);
    exp_q.delete(); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    cmp_issued("t3_order");
    repeat (4) step();

    // Continuous writebacks: waiting miss is forced out after exactly 8 writeback wins.
    issued.delete();
    push_m(8'h40, 1'b0);
    for (int i = 0; i < 12; i++) push_w(8'h80 + 8'(i), 1'b0);
    wait_issued(13, 200);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h80 + 8'(i));
    exp_q.push_back(8'h40);
    for (int i = 8; i < 12; i++) exp_q.push_back(8'h80 + 8'(i));
    cmp_issued("t4_starve");
    repeat (4) step();

    // Output stalled: four misses fill the FIFO, the fifth is held unacked.
    io.mem_request_ack_in = 1'b0;
    issued.delete();
    push_w(8'h5A, 1'b0);
    repeat (4) step();
    check("t5_busy", io.mem_request_valid_out, 1);
    miss_acks = 0;
    for (int i = 0; i < 5; i++) push_m(8'h60 + 8'(i), 1'b0);
    repeat (20) step();
    check("t5_acks_full", miss_acks, 4);
    check("t5_fifth_pending", m_pend.size(), 1);
    check("t5_no_ack_full", io.miss_request_ack_out, 0);
    io.mem_request_ack_in = 1'b1;
    wait_issued(6, 100);
    check("t5_acks_total", miss_acks, 5);
    exp_q.delete();
    exp_q.push_back(8'h5A);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h60 + 8'(i));
    cmp_issued("t5_order");
    repeat (4) step();

    // Reset while busy with three misses queued discards everything.
    io.mem_request_ack_in = 1'b0;
    issued.delete();
    push_w(8'h70, 1'b0);
    for (int i = 1; i <= 3; i++) push_m(8'h70 + 8'(i), 1'b0);
    repeat (12) step();
    check("t6_busy", io.mem_request_valid_out, 1);
    reset_in = 1'b1;
    m_pend.delete();
    w_pend.delete();
    step();
    reset_in = 1'b0;
    check("t6_valid", io.mem_request_valid_out, 0);
    check("t6_miss_ack", io.miss_request_ack_out, 0);
    check("t6_wb_ack", io.writeback_request_ack_out, 0);
    io.mem_request_ack_in = 1'b1;
    repeat (10) step();
    check("t6_nothing_issued", issued.size(), 0);
    check("t6_still_idle", io.mem_request_valid_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
